// File: rtl/window_accum.sv
// Window accumulator: sums each group of LEN unsigned samples and holds one result on a valid/ready output.
// Optional saturating arithmetic with a per-window sticky flag when WINDOW_ACCUM_SAT_EN is defined.
module window_accum #(
    parameter int WIDTH = 8,
    parameter int LEN   = 4,
    parameter int ACC_W = 2*WIDTH+2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [2*WIDTH-1:0] data_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic               out_sat,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN-1);

    // Output register state; out_valid is the state bit itself.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last;
    logic             close;

    assign out_valid = (state == ST_HOLD);
    assign last      = (cnt == CNT_LAST);
    // Valid/ready: a transfer happens on a cycle where both are high; only the closing sample can stall.
    assign in_ready  = !(out_valid && !out_ready && last);
    assign accept    = in_valid && in_ready;
    assign close     = accept && last && !clear;

`ifdef WINDOW_ACCUM_SAT_EN
    logic [ACC_W:0] sum_full;
    logic           sat_flag;
    logic           win_sat;

    assign sum_full = {1'b0, acc} + {1'b0, ACC_W'(data_in)};
    assign sum      = sum_full[ACC_W] ? '1 : sum_full[ACC_W-1:0];
    assign win_sat  = sat_flag | sum_full[ACC_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_flag <= 1'b0;
            out_sat  <= 1'b0;
        end else begin
            if (clear || close)
                sat_flag <= 1'b0;
            else if (accept)
                sat_flag <= win_sat;
            if (close)
                out_sat <= win_sat;
        end
    end
`else
    assign sum     = acc + ACC_W'(data_in);
    assign out_sat = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
            state    <= ST_IDLE;
        end else begin
            // clear discards the partial window, including a sample accepted this cycle.
            if (clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                if (last) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end

            if (close) begin
                state    <= ST_HOLD;
                out_data <= sum;
            end else if (out_valid && out_ready) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_window_accum.sv
// Directed bench for window_accum: basic, back-to-back, back-pressure, saturation, clear and reset.
module tb_window_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [15:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] out_data;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;

    logic        s_clear;
    logic [15:0] s_data_in;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [16:0] s_out_data;
    logic        s_out_sat;
    logic        s_out_valid;
    logic        s_out_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    window_accum #(.WIDTH(8), .LEN(4), .ACC_W(18)) dut (
        .clk(clk), .reset(reset), .clear(clear), .data_in(data_in),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready)
    );

    window_accum #(.WIDTH(8), .LEN(4), .ACC_W(17)) dut_s (
        .clk(clk), .reset(reset), .clear(s_clear), .data_in(s_data_in),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .out_data(s_out_data),
        .out_sat(s_out_sat), .out_valid(s_out_valid), .out_ready(s_out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; data_in = '0; in_valid = 1'b0; out_ready = 1'b1;
        s_clear = 1'b0; s_data_in = '0; s_in_valid = 1'b0; s_out_ready = 1'b1;
        step();
        step();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data",  32'(out_data),  32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        reset = 1'b0;
        step();

        // Basic window 1+2+3+4
        for (int i = 1; i <= 4; i++) begin
            data_in = 16'(i); in_valid = 1'b1;
            step();
            if (i == 3) check("basic_no_early_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_data",  32'(out_data),  32'd10);
        check("basic_sat",   32'(out_sat),   32'd0);
        step();
        check("basic_valid_drop", 32'(out_valid), 32'd0);

        // Back-to-back windows 1..8
        for (int i = 1; i <= 8; i++) begin
            data_in = 16'(i); in_valid = 1'b1;
            #1;
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            step();
            if (i == 4) check("b2b_first", 32'(out_data), 32'd10);
            if (i == 5) check("b2b_gap_valid", 32'(out_valid), 32'd0);
            if (i == 8) begin
                check("b2b_second_valid", 32'(out_valid), 32'd1);
                check("b2b_second", 32'(out_data), 32'd26);
            end
        end
        in_valid = 1'b0;
        step();

        // Back-pressure with eight samples of 5
        out_ready = 1'b0;
        data_in = 16'd5; in_valid = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 4) begin
                check("bp_first_valid", 32'(out_valid), 32'd1);
                check("bp_first_data",  32'(out_data),  32'd20);
            end
        end
        check("bp_stall", 32'(in_ready), 32'd0);
        step();
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_data",  32'(out_data),  32'd20);
        check("bp_still_stall", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_data",  32'(out_data),  32'd20);
        step();
        check("bp_drain", 32'(out_valid), 32'd0);

        // Saturation on the 17-bit instance: 4 x 65025
        s_data_in = 16'd65025; s_in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) step();
        s_in_valid = 1'b0;
        check("sat_valid", 32'(s_out_valid), 32'd1);
`ifdef WINDOW_ACCUM_SAT_EN
        check("sat_data", 32'(s_out_data), 32'd131071);
        check("sat_flag", 32'(s_out_sat),  32'd1);
`else
        check("sat_data", 32'(s_out_data), 32'd129028);
        check("sat_flag", 32'(s_out_sat),  32'd0);
`endif
        step();

        // clear mid-window discards 7,7 and the sample 9 accepted alongside it
        data_in = 16'd7; in_valid = 1'b1;
        step();
        step();
        clear = 1'b1; data_in = 16'd9;
        #1;
        check("clear_in_ready", 32'(in_ready), 32'd1);
        step();
        clear = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            data_in = 16'(i);
            step();
        end
        in_valid = 1'b0;
        check("clear_valid", 32'(out_valid), 32'd1);
        check("clear_data",  32'(out_data),  32'd10);

        // clear while holding leaves the held result untouched
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_hold_valid", 32'(out_valid), 32'd1);
        check("clear_hold_data",  32'(out_data),  32'd10);

        // Partial window, then asynchronous reset while holding
        data_in = 16'd50; in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_sat",   32'(out_sat),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            data_in = 16'(i); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data",  32'(out_data),  32'd10);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
